// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared types and constants for the floating-point pre-normalization adder
// and the normalization barrel shifter that consumes its output.
//   EXP_W   : biased exponent width
//   MAN_W   : mantissa width, explicit leading bit (fixed to the shifter width)
//   SHIFT_W : width of the left-shift magnitude driven to the shifter
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int EXP_W   = 5;
  localparam int MAN_W   = 8;
  localparam int SHIFT_W = 3;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_operand_t;

  // Result bundle handed to the shifter stage.
  typedef struct packed {
    logic               sign;
    logic [EXP_W-1:0]   exp;
    logic [MAN_W-1:0]   man;
    logic [SHIFT_W-1:0] shift;
    logic               zero;
    logic               ovf;
  } fp_prenorm_t;

  // Magnitude compare: exponent first, then mantissa. Equal magnitudes
  // report a >= b so that A stays the larger operand on a tie.
  function automatic logic mag_ge(input fp_operand_t a, input fp_operand_t b);
    return {a.exp, a.man} >= {b.exp, b.man};
  endfunction

endpackage

// File: rtl/fp_prenorm_add_lzc8.sv
// -----------------------------------------------------------------------------
// lzc8
// Combinational 8-bit leading-zero counter.
//   din   : value to scan, bit 7 is the most significant
//   count : number of leading zeros, 0..8 (8 means din is all zeros)
// The caller is responsible for clamping the count.
// -----------------------------------------------------------------------------
module lzc8 (
  input  logic [7:0] din,
  output logic [3:0] count
);

  // Scan upward so the highest set bit is the last one to write count.
  always_comb begin
    count = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (din[i]) count = 4'(7 - i);
    end
  end

endmodule

// File: rtl/fp_prenorm_add.sv
// -----------------------------------------------------------------------------
// fp_prenorm_add
// Two-stage floating-point mantissa add/subtract that feeds the 8-bit left
// barrel shifter used for normalization.
//   Stage 1 orders the operands by magnitude and aligns the smaller one
//   (truncating shift, no guard/sticky bits).
//   Stage 2 performs the effective add or subtract and derives the
//   normalization shift, adjusted exponent, zero and overflow flags.
//
// Ports
//   clk, rst              : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready   : operand handshake
//   op_sub                : 1 = A-B, 0 = A+B
//   a_*, b_*              : operand sign, biased exponent, mantissa
//   out_valid / out_ready : result handshake
//   out_sign, out_exp     : result sign, exponent already adjusted for shift
//   out_man, out_shift    : pre-shift mantissa and left-shift magnitude
//   out_zero, out_ovf     : exact-zero result, exponent saturated
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and data stable until the transfer. A stage
// loads when it is empty or when its contents move on in the same cycle, so
// in_ready depends combinationally on out_ready. Results are held stable while
// out_valid is high and out_ready is low.
// -----------------------------------------------------------------------------
module fp_prenorm_add
  import fp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op_sub,
  input  logic               a_sign,
  input  logic               b_sign,
  input  logic [EXP_W-1:0]   a_exp,
  input  logic [EXP_W-1:0]   b_exp,
  input  logic [MAN_W-1:0]   a_man,
  input  logic [MAN_W-1:0]   b_man,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [EXP_W-1:0]   out_exp,
  output logic [MAN_W-1:0]   out_man,
  output logic [SHIFT_W-1:0] out_shift,
  output logic               out_zero,
  output logic               out_ovf
);

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic in_fire;
  logic s2_load;

  assign s2_load  = s1_valid & (!s2_valid | out_ready);
  assign in_ready = !s1_valid | !s2_valid | out_ready;
  assign in_fire  = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: order and align
  // ---------------------------------------------------------------------------
  fp_operand_t      a_op;
  fp_operand_t      b_op;
  fp_operand_t      l_op;
  fp_operand_t      s_op;
  logic             a_is_l;
  logic             eff_sub;
  logic [EXP_W-1:0] align_d;
  logic [MAN_W-1:0] s_man_al;

  // B carries its effective sign (op_sub folded in), so when B is the larger
  // operand its sign is directly the result sign.
  assign a_op = '{sign: a_sign,          exp: a_exp, man: a_man};
  assign b_op = '{sign: b_sign ^ op_sub, exp: b_exp, man: b_man};

  assign a_is_l  = mag_ge(a_op, b_op);
  assign l_op    = a_is_l ? a_op : b_op;
  assign s_op    = a_is_l ? b_op : a_op;
  assign eff_sub = l_op.sign ^ s_op.sign;
  assign align_d = l_op.exp - s_op.exp;

  // Shifts of MAN_W or more flush the smaller mantissa completely.
  assign s_man_al = (align_d >= EXP_W'(MAN_W)) ? '0 : (s_op.man >> align_d);

  fp_operand_t      s1_l;
  logic [MAN_W-1:0] s1_s_man;
  logic             s1_eff_sub;

  // ---------------------------------------------------------------------------
  // Stage 2: add/subtract and normalization control
  // ---------------------------------------------------------------------------
  logic [MAN_W:0]   sum;
  logic [3:0]       lz;
  logic [EXP_W-1:0] lz_ext;
  fp_prenorm_t      res;
  fp_prenorm_t      out_r;

  assign sum = s1_eff_sub ? ({1'b0, s1_l.man} - {1'b0, s1_s_man})
                          : ({1'b0, s1_l.man} + {1'b0, s1_s_man});

  lzc8 u_lzc8 (
    .din   (sum[MAN_W-1:0]),
    .count (lz)
  );

  assign lz_ext = EXP_W'(lz);

  always_comb begin
    res      = '0;
    res.sign = s1_l.sign;
    if (!s1_eff_sub && sum[MAN_W]) begin
      // Carry out: renormalize right by one.
      if (s1_l.exp == EXP_MAX) begin
        res.exp = EXP_MAX;
        res.man = '1;
        res.ovf = 1'b1;
      end else begin
        res.exp = s1_l.exp + 1'b1;
        res.man = sum[MAN_W:1];
      end
    end else if (lz[3] && !sum[MAN_W]) begin
      // Exact zero: canonical +0.
      res      = '0;
      res.zero = 1'b1;
    end else begin
      // Never shift below exponent 0; the remainder stays denormal.
      if (lz_ext < s1_l.exp) res.shift = lz[SHIFT_W-1:0];
      else                   res.shift = s1_l.exp[SHIFT_W-1:0];
      res.exp = s1_l.exp - EXP_W'(res.shift);
      res.man = sum[MAN_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_l       <= '0;
      s1_s_man   <= '0;
      s1_eff_sub <= 1'b0;
      s2_valid   <= 1'b0;
      out_r      <= '0;
    end else begin
      if (in_fire) begin
        s1_valid   <= 1'b1;
        s1_l       <= l_op;
        s1_s_man   <= s_man_al;
        s1_eff_sub <= eff_sub;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        s2_valid <= 1'b1;
        out_r    <= res;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_sign  = out_r.sign;
  assign out_exp   = out_r.exp;
  assign out_man   = out_r.man;
  assign out_shift = out_r.shift;
  assign out_zero  = out_r.zero;
  assign out_ovf   = out_r.ovf;

endmodule

// File: tb/tb_fp_prenorm_add.sv
// -----------------------------------------------------------------------------
// tb_fp_prenorm_add
// Bench for fp_prenorm_add: directed cases with hand-computed results, a
// back-pressure stream, a mid-flight reset, and randomized operands checked
// against an arithmetic reference model through an in-order expected queue.
// -----------------------------------------------------------------------------
module tb_fp_prenorm_add;
  import fp_pkg::*;

  localparam int RW = 1 + EXP_W + MAN_W + SHIFT_W + 2;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               op_sub = 1'b0;
  logic               a_sign = 1'b0;
  logic               b_sign = 1'b0;
  logic [EXP_W-1:0]   a_exp = '0;
  logic [EXP_W-1:0]   b_exp = '0;
  logic [MAN_W-1:0]   a_man = '0;
  logic [MAN_W-1:0]   b_man = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               out_sign;
  logic [EXP_W-1:0]   out_exp;
  logic [MAN_W-1:0]   out_man;
  logic [SHIFT_W-1:0] out_shift;
  logic               out_zero;
  logic               out_ovf;
  logic [RW-1:0]      out_vec;

  always #5 clk = ~clk;

  fp_prenorm_add dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a_sign    (a_sign),
    .b_sign    (b_sign),
    .a_exp     (a_exp),
    .b_exp     (b_exp),
    .a_man     (a_man),
    .b_man     (b_man),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_man   (out_man),
    .out_shift (out_shift),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
  );

  assign out_vec = {out_sign, out_exp, out_man, out_shift, out_zero, out_ovf};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Checking and reference model
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [RW-1:0] pack(input logic s, input int e, input int m,
                                         input int sh, input logic z, input logic o);
    logic [RW-1:0] r;
    r = {s, EXP_W'(e), MAN_W'(m), SHIFT_W'(sh), z, o};
    return r;
  endfunction

  // Result straight from the arithmetic rules, using integer magnitudes.
  function automatic logic [RW-1:0] model(input logic as, input int ae, input int am,
                                          input logic bs, input int be, input int bm,
                                          input logic op);
    logic bse, ls, sub;
    int   le, lm, se, sm, d, sum, z, v, sh;
    bse = bs ^ op;
    sub = as ^ bse;
    if (ae * 256 + am >= be * 256 + bm) begin
      ls = as;  le = ae; lm = am; se = be; sm = bm;
    end else begin
      ls = bse; le = be; lm = bm; se = ae; sm = am;
    end
    d   = le - se;
    sm  = (d >= 8) ? 0 : (sm >> d);
    sum = sub ? (lm - sm) : (lm + sm);
    if (sum >= 256) begin
      if (le == 31) return pack(ls, 31, 255, 0, 1'b0, 1'b1);
      return pack(ls, le + 1, sum / 2, 0, 1'b0, 1'b0);
    end
    if (sum == 0) return pack(1'b0, 0, 0, 0, 1'b1, 1'b0);
    z = 0;
    v = sum;
    while (v < 128) begin
      v = v * 2;
      z++;
    end
    sh = (z < le) ? z : le;
    return pack(ls, le - sh, sum, sh, 1'b0, 1'b0);
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [RW-1:0] exp_q[$];
  int            lat_q[$];
  logic          dir_use  = 1'b0;
  logic [RW-1:0] dir_exp  = '0;
  logic          chk_lat  = 1'b0;
  logic          rand_bp  = 1'b0;
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_vec = '0;

  always @(negedge clk) begin
    logic [RW-1:0] w;
    int            t;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold", {out_valid, out_vec}, {1'b1, prev_vec});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          t = lat_q.pop_front();
          check("result", out_vec, w);
          if (chk_lat) check("latency", cyc - t, 32'd2);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(dir_use ? dir_exp
                                : model(a_sign, a_exp, a_man, b_sign, b_exp, b_man, op_sub));
        lat_q.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_vec   = out_vec;
    end
  end

  // Random back-pressure while enabled.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_op(input logic as, input logic [EXP_W-1:0] ae, input logic [MAN_W-1:0] am,
                          input logic bs, input logic [EXP_W-1:0] be, input logic [MAN_W-1:0] bm,
                          input logic op);
    int n;
    n = 0;
    a_sign = as; a_exp = ae; a_man = am;
    b_sign = bs; b_exp = be; b_man = bm;
    op_sub = op;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_dir(input logic as, input int ae, input int am,
                           input logic bs, input int be, input int bm,
                           input logic op, input logic [RW-1:0] want);
    dir_use = 1'b1;
    dir_exp = want;
    drive_op(as, EXP_W'(ae), MAN_W'(am), bs, EXP_W'(be), MAN_W'(bm), op);
    dir_use = 1'b0;
  endtask

  task automatic drive_rand();
    logic             as, bs, op;
    logic [EXP_W-1:0] ae, be;
    logic [MAN_W-1:0] am, bm;
    int               r;
    as = 1'($urandom_range(0, 1));
    bs = 1'($urandom_range(0, 1));
    op = 1'($urandom_range(0, 1));
    ae = EXP_W'($urandom_range(0, 31));
    be = EXP_W'($urandom_range(0, 31));
    am = {1'b1, 7'($urandom_range(0, 127))};
    bm = {1'b1, 7'($urandom_range(0, 127))};
    r  = $urandom_range(0, 9);
    if (r == 0) begin
      be = ae;
      bm = am;
    end else if (r == 1) begin
      ae = 5'd31;
      be = EXP_W'($urandom_range(24, 31));
    end else if (r == 2) begin
      be = ae;
    end
    drive_op(as, ae, am, bs, be, bm, op);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int ghost;
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_out_data", out_vec, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 32'd1);

    // Directed cases, streamed with out_ready held high.
    chk_lat = 1'b1;
    drive_dir(0, 10, 'h80, 0, 10, 'h80, 0, pack(0, 11, 'h80, 0, 0, 0));
    drive_dir(0, 10, 'h90, 0, 10, 'h80, 1, pack(0,  7, 'h10, 3, 0, 0));
    drive_dir(1,  6, 'hA0, 1,  6, 'hA0, 1, pack(0,  0, 'h00, 0, 1, 0));
    drive_dir(0,  4, 'h80, 0,  6, 'h80, 1, pack(1,  5, 'h60, 1, 0, 0));
    drive_dir(0, 20, 'hC0, 0,  5, 'hFF, 0, pack(0, 20, 'hC0, 0, 0, 0));
    drive_dir(0,  2, 'h88, 0,  2, 'h80, 1, pack(0,  0, 'h08, 2, 0, 0));
    drive_dir(0, 31, 'hFF, 0, 31, 'h01, 0, pack(0, 31, 'hFF, 0, 0, 1));
    drive_dir(0, 15, 'h80, 0,  8, 'hFF, 0, pack(0, 15, 'h81, 0, 0, 0));
    drive_dir(0, 15, 'h80, 0,  7, 'hFF, 0, pack(0, 15, 'h80, 0, 0, 0));
    drive_dir(0,  9, 'hA0, 1,  9, 'hA0, 0, pack(0,  0, 'h00, 0, 1, 0));
    wait_drain();
    chk_lat = 1'b0;

    // Back-pressure: 4 ops, out_ready low for 3 cycles once results appear.
    fork
      begin
        for (int i = 0; i < 4; i++) drive_rand();
      end
      begin
        n = 0;
        @(posedge clk);
        #1;
        while (!out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("stall_first_valid", out_valid, 32'd1);
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", in_ready, 32'd0);
        check("stall_out_valid", out_valid, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with two operations in flight.
    out_ready = 1'b0;
    drive_rand();
    drive_rand();
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(posedge clk);
    #1;
    check("rst_mid_out_valid", out_valid, 32'd0);
    check("rst_mid_out_data", out_vec, 32'd0);
    check("rst_mid_in_ready", in_ready, 32'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    ghost = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) ghost++;
    end
    check("no_ghost_after_rst", ghost, 32'd0);

    // Randomized operands with random back-pressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) drive_rand();
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_prenorm_add.md
# fp_prenorm_add

Pipelined floating-point mantissa add/subtract stage that sits directly upstream of the 8-bit left barrel shifter used for normalization. It aligns two operands, performs the effective add or subtract, and produces an un-normalized 8-bit mantissa plus a 3-bit left-shift magnitude. These feed the shifter's data input and shift-select input. The shifter output is the normalized mantissa.

## Interface
Clocking: one clock; reset is synchronous and active-high.

Parameters:
- EXP_W, 5, exponent width.
- MAN_W, 8, mantissa width. Explicit leading bit; man[MAN_W-1]=1 when normalized. Fixed to 8 to match the shifter.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept
- op_sub  in  1  1 = A−B, 0 = A+B
- a_sign, b_sign  in  1 each  operand signs
- a_exp, b_exp  in  EXP_W each  biased exponents
- a_man, b_man  in  MAN_W each  mantissas
- out_valid  out  1  result valid
- out_ready  in  1  downstream (shifter/register) accepts
- out_sign  out  1  result sign
- out_exp  out  EXP_W  exponent already adjusted for the shift
- out_man  out  MAN_W  pre-shift mantissa, to shifter Ip
- out_shift  out  3  left-shift magnitude, to shifter shift_mag
- out_zero  out  1  exact-zero result
- out_ovf  out  1  exponent saturated at 2^EXP_W−1

## Operation
- Effective subtract: eff_sub = a_sign ^ b_sign ^ op_sub.
- **Stage 1 (align):**
  - Order the operands by magnitude: compare exponent first, then mantissa. The larger operand is L, the smaller is S; ties keep A as L.
  - d = L.exp − S.exp. If d ≥ 8, S.man is replaced by 0; otherwise S.man = S.man >> d, truncated (no guard or sticky bits).
  - Result sign = L.sign.
- **Stage 2 (add/normalize control):**
  - sum = L.man ± S.man, computed in 9 bits.
  - **Add with carry (sum[8]=1):** out_man = sum[8:1], out_exp = L.exp+1, out_shift = 0. If L.exp = 2^EXP_W−1: out_exp saturates at 2^EXP_W−1, out_ovf = 1, out_man = 0xFF.
  - **sum = 0:** out_zero = 1, out_sign = 0, out_exp = 0, out_man = 0, out_shift = 0.
  - **Otherwise:**
    - z = leading-zero count of sum[7:0].
    - out_shift = min(z, L.exp), which clamps into the denormal range.
    - out_exp = L.exp − out_shift.
    - out_man = sum[7:0].
- All arithmetic is unsigned, with widths as stated; no rounding.

## Timing
- Latency: 2 cycles from accepted input (in_valid & in_ready) to out_valid.
- Throughput: 1 result per cycle while out_ready = 1.
- Each stage has its own valid bit. A stage loads when it is empty or when its successor loads or drains that cycle.
  - in_ready = !s1_valid | (!s2_valid | out_ready).
  - This combinational path from out_ready to in_ready is permitted.
- Outputs hold stable while out_valid & !out_ready.
- Input and output transfers in the same cycle are both honoured; no bubble is inserted.
- Reset: s1_valid = s2_valid = 0, out_valid = 0, and all data outputs = 0. in_ready is 1 in the cycle after rst deasserts.
- Reset asserted mid-operation discards all in-flight results; nothing is emitted afterwards.
- Inputs are sampled only on accepted cycles; in_valid low means no operation.

## Structure
- Shared package fp_pkg holds:
  - constants EXP_W, MAN_W, SHIFT_W = 3;
  - struct fp_operand_t {sign, exp, man};
  - struct fp_prenorm_t mirroring the output bundle.
- The shifter integration uses the same package.
- One sub-module: lzc8, a combinational 8-bit leading-zero counter with output 0..8. Its result is clamped by the parent.
- Pipeline registers are inline in fp_prenorm_add.

## Test plan
- Carry-out: a=(+,10,0x80), b=(+,10,0x80), add → man 0x80, exp 11, shift 0, sign +, after 2 cycles.
- Cancellation with shift: a=(+,10,0x90), b=(+,10,0x80), sub → man 0x10, shift 3, exp 7, sign +.
- Exact zero and operand swap:
  - a=(−,6,0xA0), b=(−,6,0xA0), sub → zero=1, sign +, exp 0.
  - a=(+,4,0x80), b=(+,6,0x80), sub → sign −, man 0x60, shift 1, exp 5.
- Large difference and denormal clamp:
  - a=(+,20,0xC0), b=(+,5,0xFF), add → man 0xC0, exp 20, shift 0.
  - a=(+,2,0x88), b=(+,2,0x80), sub → man 0x08, shift 2, exp 0.
- Overflow: a=(+,31,0xFF), b=(+,31,0x01), add → exp 31, ovf=1, man 0xFF.
- Back-pressure and reset:
  - Stream 4 ops with out_ready low for 3 cycles mid-stream → outputs held, order preserved, in_ready low once both stages are full.
  - Assert rst with 2 ops in flight → out_valid = 0 next cycle, and neither op ever appears.
